// File: rtl/csr_ctrl.sv
// csr_ctrl -- writeback-stage CSR initiator and commit arbiter.
//
// Turns the retiring WB instruction into a CSR write/read request, and
// arbitrates interrupt > exception > ertn > CSR op into single-cycle
// commit pulses. Any interrupt, exception or ertn commit raises a held
// fetch redirect toward the exception entry or the return address.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   ws_*              retiring WB instruction (valid, pc, csr op/num,
//                     mask/data, upstream exception, ertn)
//   ws_csr_rdata      CSR read result to the regfile (= csr_rval)
//   csr_we/wnum/wmask/wval, csr_rnum, csr_rval
//                     CSR file write/read port
//   wb_exc/wb_ecode/wb_esubcode/wb_pc, ertn_flush
//                     exception / ertn commit pulses to the CSR file
//   has_int, exc_entry, exc_retaddr
//                     interrupt level and redirect targets from the CSR file
//   redir_valid/redir_pc/redir_ready
//                     fetch redirect handshake to IF
//
// Redirect handshake: redir_valid is raised by this block and stays high,
// with redir_pc unchanged, until the cycle in which redir_ready is also
// high; that cycle is the transfer, and redir_valid drops on the next edge.
// redir_ready has no effect while redir_valid is low.

module csr_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ws_valid,
    input  logic [31:0] ws_pc,
    input  logic [1:0]  ws_csr_op,
    input  logic [13:0] ws_csr_num,
    input  logic [31:0] ws_rj_value,
    input  logic [31:0] ws_rd_value,
    input  logic        ws_exc,
    input  logic [5:0]  ws_ecode,
    input  logic [8:0]  ws_esubcode,
    input  logic        ws_ertn,
    output logic [31:0] ws_csr_rdata,
    output logic        csr_we,
    output logic [13:0] csr_wnum,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wval,
    output logic [13:0] csr_rnum,
    input  logic [31:0] csr_rval,
    output logic        wb_exc,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic        ertn_flush,
    input  logic        has_int,
    input  logic [31:0] exc_entry,
    input  logic [31:0] exc_retaddr,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready
);

    localparam logic [1:0] OP_CSRWR   = 2'd2;
    localparam logic [1:0] OP_CSRXCHG = 2'd3;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_REDIR = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        int_q;
    logic [31:0] redir_pc_q, redir_pc_d;

    // Interrupt level is sampled one cycle late; this lag is what lets an
    // IE clear committed at T be seen as int_q=0 by T+2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            int_q      <= 1'b0;
            redir_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            int_q      <= has_int;
            redir_pc_q <= redir_pc_d;
        end
    end

    // Read path is always live, so csrwr/csrxchg see the pre-write value.
    assign ws_csr_rdata = csr_rval;
    assign csr_rnum     = ws_csr_num;
    assign csr_wnum     = ws_csr_num;
    assign redir_valid  = (state_q == S_REDIR);
    assign redir_pc     = redir_pc_q;

    always_comb begin
        state_d     = state_q;
        redir_pc_d  = redir_pc_q;
        csr_we      = 1'b0;
        csr_wmask   = 32'h0;
        csr_wval    = 32'h0;
        wb_exc      = 1'b0;
        wb_ecode    = 6'h0;
        wb_esubcode = 9'h0;
        wb_pc       = 32'h0;
        ertn_flush  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ws_valid) begin
                    if (int_q) begin
                        // Interrupt preempts the instruction: it does not commit.
                        wb_exc     = 1'b1;
                        wb_pc      = ws_pc;
                        redir_pc_d = exc_entry;
                        state_d    = S_REDIR;
                    end else if (ws_exc) begin
                        wb_exc      = 1'b1;
                        wb_ecode    = ws_ecode;
                        wb_esubcode = ws_esubcode;
                        wb_pc       = ws_pc;
                        redir_pc_d  = exc_entry;
                        state_d     = S_REDIR;
                    end else if (ws_ertn) begin
                        ertn_flush = 1'b1;
                        redir_pc_d = exc_retaddr;
                        state_d    = S_REDIR;
                    end else if (ws_csr_op == OP_CSRWR) begin
                        csr_we    = 1'b1;
                        csr_wmask = 32'hFFFF_FFFF;
                        csr_wval  = ws_rd_value;
                    end else if (ws_csr_op == OP_CSRXCHG) begin
                        csr_we    = 1'b1;
                        csr_wmask = ws_rj_value;
                        csr_wval  = ws_rd_value;
                    end
                end
            end
            S_REDIR: begin
                // Younger instructions reaching WB here are on the wrong
                // path, so every strobe stays low.
                if (redir_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_ctrl.sv
module tb_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic [1:0]  ws_csr_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rj_value;
  logic [31:0] ws_rd_value;
  logic        ws_exc;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic        ws_ertn;
  logic [31:0] ws_csr_rdata;
  logic        csr_we;
  logic [13:0] csr_wnum;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wval;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rval;
  logic        wb_exc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic        has_int;
  logic [31:0] exc_entry;
  logic [31:0] exc_retaddr;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: is a redirect outstanding, where to, and the
  // interrupt level as seen one cycle ago
  bit          m_redir;
  logic [31:0] m_redir_pc;
  bit          m_int;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  csr_ctrl dut (
    .clk(clk), .rst(rst),
    .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_csr_op(ws_csr_op),
    .ws_csr_num(ws_csr_num), .ws_rj_value(ws_rj_value),
    .ws_rd_value(ws_rd_value), .ws_exc(ws_exc), .ws_ecode(ws_ecode),
    .ws_esubcode(ws_esubcode), .ws_ertn(ws_ertn),
    .ws_csr_rdata(ws_csr_rdata), .csr_we(csr_we), .csr_wnum(csr_wnum),
    .csr_wmask(csr_wmask), .csr_wval(csr_wval), .csr_rnum(csr_rnum),
    .csr_rval(csr_rval), .wb_exc(wb_exc), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .ertn_flush(ertn_flush),
    .has_int(has_int), .exc_entry(exc_entry), .exc_retaddr(exc_retaddr),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_redir    = 1'b0;
    m_redir_pc = 32'h0;
    m_int      = 1'b0;
  endtask

  // At the falling edge, compare every output against what the current
  // inputs and the reference state say should be happening.
  task automatic check_now();
    bit live, e_int, e_exc, e_ertn, e_wr;
    @(negedge clk);
    live   = ws_valid && !m_redir;
    e_int  = live && m_int;
    e_exc  = live && !m_int && ws_exc;
    e_ertn = live && !m_int && !ws_exc && ws_ertn;
    e_wr   = live && !m_int && !ws_exc && !ws_ertn && (ws_csr_op >= 2'd2);
    chk("redir_valid", {31'b0, redir_valid}, {31'b0, m_redir});
    chk("redir_pc", redir_pc, m_redir_pc);
    chk("csr_we", {31'b0, csr_we}, {31'b0, e_wr});
    chk("wb_exc", {31'b0, wb_exc}, {31'b0, e_int || e_exc});
    chk("ertn_flush", {31'b0, ertn_flush}, {31'b0, e_ertn});
    chk("ws_csr_rdata", ws_csr_rdata, csr_rval);
    chk("csr_wnum", {18'b0, csr_wnum}, {18'b0, ws_csr_num});
    chk("csr_rnum", {18'b0, csr_rnum}, {18'b0, ws_csr_num});
    if (e_wr) begin
      chk("csr_wmask", csr_wmask, (ws_csr_op == 2'd2) ? 32'hFFFF_FFFF : ws_rj_value);
      chk("csr_wval", csr_wval, ws_rd_value);
    end
    if (e_int || e_exc) begin
      chk("wb_ecode", {26'b0, wb_ecode}, e_int ? 32'h0 : {26'b0, ws_ecode});
      chk("wb_esubcode", {23'b0, wb_esubcode}, e_int ? 32'h0 : {23'b0, ws_esubcode});
      chk("wb_pc", wb_pc, ws_pc);
    end
  endtask

  // Advance the reference state across the rising edge, then move just past it.
  task automatic step();
    bit live;
    @(posedge clk);
    live = ws_valid && !m_redir;
    if (m_redir) begin
      if (redir_ready) m_redir = 1'b0;
    end else if (live && (m_int || ws_exc)) begin
      m_redir    = 1'b1;
      m_redir_pc = exc_entry;
    end else if (live && ws_ertn) begin
      m_redir    = 1'b1;
      m_redir_pc = exc_retaddr;
    end
    m_int = has_int;
    #1;
  endtask

  task automatic cyc();
    check_now();
    step();
  endtask

  task automatic idle_wb();
    ws_valid  = 1'b0;
    ws_exc    = 1'b0;
    ws_ertn   = 1'b0;
    ws_csr_op = 2'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_wb();
    ws_pc = 32'h0; ws_csr_num = 14'h0; ws_rj_value = 32'h0; ws_rd_value = 32'h0;
    ws_ecode = 6'h0; ws_esubcode = 9'h0; csr_rval = 32'h0; has_int = 1'b0;
    exc_entry = 32'h0; exc_retaddr = 32'h0; redir_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst redir_valid", {31'b0, redir_valid}, 32'h0);
    chk("rst redir_pc", redir_pc, 32'h0);
    chk("rst csr_we", {31'b0, csr_we}, 32'h0);
    chk("rst wb_exc", {31'b0, wb_exc}, 32'h0);
    chk("rst ertn_flush", {31'b0, ertn_flush}, 32'h0);
    rst = 1'b0;

    // csrwr
    ws_valid = 1'b1; ws_csr_op = 2'd2; ws_csr_num = 14'h30;
    ws_rd_value = 32'hDEAD_BEEF; csr_rval = 32'h1234;
    check_now();
    chk("csrwr we", {31'b0, csr_we}, 32'h1);
    chk("csrwr wmask", csr_wmask, 32'hFFFF_FFFF);
    chk("csrwr wval", csr_wval, 32'hDEAD_BEEF);
    chk("csrwr rdata", ws_csr_rdata, 32'h1234);
    step();
    // csrxchg
    ws_csr_op = 2'd3; ws_rj_value = 32'h0000_00FF; ws_rd_value = 32'hAAAA_AAAA;
    check_now();
    chk("xchg we", {31'b0, csr_we}, 32'h1);
    chk("xchg wmask", csr_wmask, 32'h0000_00FF);
    chk("xchg wval", csr_wval, 32'hAAAA_AAAA);
    step();
    // csrrd
    ws_csr_op = 2'd1;
    check_now();
    chk("csrrd we", {31'b0, csr_we}, 32'h0);
    step();

    // syscall, redirect held for 3 cycles, younger csrwr squashed
    ws_csr_op = 2'd0; ws_exc = 1'b1; ws_ecode = 6'h0B; ws_esubcode = 9'h0;
    ws_pc = 32'h1C00_0100; exc_entry = 32'h1C00_8000;
    check_now();
    chk("sys wb_exc", {31'b0, wb_exc}, 32'h1);
    chk("sys ecode", {26'b0, wb_ecode}, 32'h0B);
    chk("sys pc", wb_pc, 32'h1C00_0100);
    step();
    ws_exc = 1'b0; ws_csr_op = 2'd2; exc_entry = 32'h0BAD_0000;
    repeat (3) begin
      check_now();
      chk("hold redir_valid", {31'b0, redir_valid}, 32'h1);
      chk("hold redir_pc", redir_pc, 32'h1C00_8000);
      chk("squash csr_we", {31'b0, csr_we}, 32'h0);
      step();
    end
    idle_wb(); redir_ready = 1'b1;
    cyc();
    redir_ready = 1'b0;
    check_now();
    chk("back idle", {31'b0, redir_valid}, 32'h0);
    step();

    // ertn
    exc_retaddr = 32'h1C00_0104; ws_valid = 1'b1; ws_ertn = 1'b1;
    check_now();
    chk("ertn flush", {31'b0, ertn_flush}, 32'h1);
    step();
    idle_wb();
    check_now();
    chk("ertn pulse", {31'b0, ertn_flush}, 32'h0);
    chk("ertn redir_pc", redir_pc, 32'h1C00_0104);
    redir_ready = 1'b1;
    step();
    redir_ready = 1'b0;

    // exception and ertn together: exception wins
    ws_valid = 1'b1; ws_exc = 1'b1; ws_ertn = 1'b1; ws_ecode = 6'h0B; ws_esubcode = 9'h5;
    exc_entry = 32'h1C00_8000;
    check_now();
    chk("exc+ertn wb_exc", {31'b0, wb_exc}, 32'h1);
    chk("exc+ertn flush", {31'b0, ertn_flush}, 32'h0);
    step();
    idle_wb(); redir_ready = 1'b1;
    cyc();
    redir_ready = 1'b0;

    // interrupt: level at T, csrwr at T+1 is preempted, no second interrupt
    has_int = 1'b1;
    cyc();
    has_int = 1'b0; ws_valid = 1'b1; ws_csr_op = 2'd2; ws_pc = 32'h1C00_0200;
    check_now();
    chk("int wb_exc", {31'b0, wb_exc}, 32'h1);
    chk("int ecode", {26'b0, wb_ecode}, 32'h0);
    chk("int csr_we", {31'b0, csr_we}, 32'h0);
    step();
    idle_wb(); redir_ready = 1'b1;
    cyc();
    redir_ready = 1'b0; ws_valid = 1'b1; ws_csr_op = 2'd2;
    check_now();
    chk("no 2nd int", {31'b0, wb_exc}, 32'h0);
    chk("post-int we", {31'b0, csr_we}, 32'h1);
    step();

    // asynchronous reset in the middle of a redirect
    ws_csr_op = 2'd0; ws_exc = 1'b1;
    cyc();
    idle_wb();
    check_now();
    chk("pre-rst redir", {31'b0, redir_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async rst redir_valid", {31'b0, redir_valid}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    ws_valid = 1'b1; ws_csr_op = 2'd2; ws_rd_value = 32'h5555_0001;
    check_now();
    chk("post-rst we", {31'b0, csr_we}, 32'h1);
    step();

    // randomized traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      ws_valid    = ($urandom_range(0, 3) != 0);
      ws_csr_op   = 2'($urandom_range(0, 3));
      ws_csr_num  = 14'($urandom);
      ws_rj_value = $urandom;
      ws_rd_value = $urandom;
      ws_pc       = $urandom;
      ws_exc      = ($urandom_range(0, 7) == 0);
      ws_ecode    = 6'($urandom);
      ws_esubcode = 9'($urandom);
      ws_ertn     = ($urandom_range(0, 7) == 0);
      csr_rval    = $urandom;
      has_int     = ($urandom_range(0, 9) == 0);
      exc_entry   = $urandom;
      exc_retaddr = $urandom;
      redir_ready = ($urandom_range(0, 1) == 1);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
